// File: rtl/phased_delay_pipeline.sv
// rtl/phased_delay_pipeline.sv - frame-synchronous sample delay line with 64-cycle phase counter
// Shifts NUMBER_OF_PIPE signed stages once per frame on the frame-end strobe.
module phased_delay_pipeline #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUMBER_OF_PIPE = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_enable,
    input  logic signed [DATA_WIDTH-1:0] i_signal_sample,
    output logic [5:0]                   current_count,
    output logic                         phase_0,
    output logic                         phase_63,
    output logic signed [DATA_WIDTH-1:0] o_delayed_sample
);

    logic signed [DATA_WIDTH-1:0] stage [NUMBER_OF_PIPE];

    // Free-running frame phase; natural 6-bit wrap gives the modulo-64 count.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_count <= 6'd0;
        end else if (clk_enable) begin
            current_count <= current_count + 6'd1;
        end
    end

    assign phase_0  = clk_enable && (current_count == 6'd0);
    assign phase_63 = clk_enable && (current_count == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUMBER_OF_PIPE; k++) begin
                stage[k] <= '0;
            end
        end else if (phase_63) begin
            stage[0] <= i_signal_sample;
            for (int k = 1; k < NUMBER_OF_PIPE; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    // Output is the last register itself, so it never depends on inputs combinationally.
    assign o_delayed_sample = stage[NUMBER_OF_PIPE-1];

endmodule

// File: tb/tb_phased_delay_pipeline.sv
// tb/tb_phased_delay_pipeline.sv - self-checking bench for phased_delay_pipeline
// Reference keeps the captured-sample history as a queue of frames.
module tb_phased_delay_pipeline;

    localparam int DW = 16;
    localparam int NP = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] sample;
    logic [5:0]           count;
    logic                 ph0;
    logic                 ph63;
    logic signed [DW-1:0] dout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int                   m_count;
    logic signed [DW-1:0] hist[$];

    phased_delay_pipeline #(.DATA_WIDTH(DW), .NUMBER_OF_PIPE(NP)) dut (
        .clk              (clk),
        .rst              (rst),
        .clk_enable       (en),
        .i_signal_sample  (sample),
        .current_count    (count),
        .phase_0          (ph0),
        .phase_63         (ph63),
        .o_delayed_sample (dout)
    );

    always #5 clk = ~clk;

    // Output is the sample captured NP frames ago, zero until that many captures exist.
    function automatic logic signed [DW-1:0] exp_out();
        return (hist.size() == NP) ? hist[0] : '0;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_count = 0;
            hist.delete();
        end else if (en) begin
            if (m_count == 63) begin
                hist.push_back(sample);
                if (hist.size() > NP) void'(hist.pop_front());
            end
            m_count = (m_count + 1) % 64;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sample = 16'sd0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (ph0 !== 1'b1) begin failures++; $display("FAIL reset_phase_0 got=%b exp=1", ph0); end
        checks++;
        if (ph63 !== 1'b0) begin failures++; $display("FAIL reset_phase_63 got=%b exp=0", ph63); end
        checks++;
        if (dout !== 16'sd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", dout); end
    endtask

    task automatic test_count();
        int n0 = 0;
        int n63 = 0;
        rst = 1'b0;
        for (int i = 0; i < 130; i++) begin
            step();
            if (ph0) n0++;
            if (ph63) n63++;
            checks++;
            if (count !== 6'(m_count)) begin failures++; $display("FAIL count_seq cyc=%0d got=%0d exp=%0d", i, count, m_count); end
            checks++;
            if (ph0 !== (m_count == 0) || ph63 !== (m_count == 63)) begin
                failures++; $display("FAIL count_strobes cyc=%0d got=%b%b count=%0d", i, ph0, ph63, m_count);
            end
        end
        // 130 edges from count 0: counts seen 1..63,0..63,0..2 -> two of each strobe
        checks++;
        if (n0 != 2 || n63 != 2) begin failures++; $display("FAIL count_strobe_totals got=%0d/%0d exp=2/2", n0, n63); end
        checks++;
        if (count !== 6'd2) begin failures++; $display("FAIL count_final got=%0d exp=2", count); end
    endtask

    task automatic test_impulse();
        int shift_cyc = -1;
        int first_seen = -1;
        int n_hit = 0;
        rst = 1'b1; en = 1'b1; sample = 16'sd100;
        step();
        rst = 1'b0;
        for (int i = 0; i < 64 * 67; i++) begin
            step();
            if (shift_cyc < 0 && hist.size() == 1) shift_cyc = cyc;
            if (shift_cyc >= 0 && m_count == 1) sample = 16'sd0;
            if (dout == 16'sd100) begin
                n_hit++;
                if (first_seen < 0) first_seen = cyc;
            end
            checks++;
            if (dout !== exp_out()) begin failures++; $display("FAIL impulse_out cyc=%0d got=%0d exp=%0d", i, dout, exp_out()); end
        end
        checks++;
        if (first_seen - shift_cyc != 4032) begin
            failures++; $display("FAIL impulse_latency got=%0d exp=4032", first_seen - shift_cyc);
        end
        checks++;
        if (n_hit != 64) begin failures++; $display("FAIL impulse_width got=%0d exp=64", n_hit); end
    endtask

    task automatic test_random();
        int frame = 0;
        int bad = 0;
        bit seen_neg = 0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (m_count == 1) begin
                frame++;
                sample = (frame == 100) ? -16'sd5 : DW'($urandom_range(200, 1));
            end
            if (dout === -16'sd5) seen_neg = 1;
            checks++;
            if (dout !== exp_out()) begin
                failures++;
                if (bad++ < 10) $display("FAIL random_out cyc=%0d got=%0d exp=%0d", i, dout, exp_out());
            end
        end
        checks++;
        if (!seen_neg) begin failures++; $display("FAIL random_negative got=never exp=-5"); end
    endtask

    task automatic test_enable();
        logic signed [DW-1:0] held;
        int guard = 0;
        while (m_count != 30 && guard < 200) begin
            step();
            guard++;
            if (m_count == 1) sample = DW'($urandom_range(200, 1));
        end
        checks++;
        if (count !== 6'd30) begin failures++; $display("FAIL enable_reach got=%0d exp=30", count); end
        held = dout;
        en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            checks++;
            if (count !== 6'd30 || ph0 !== 1'b0 || ph63 !== 1'b0) begin
                failures++; $display("FAIL enable_freeze cyc=%0d count=%0d strobes=%b%b exp=30/00", i, count, ph0, ph63);
            end
            checks++;
            if (dout !== held) begin failures++; $display("FAIL enable_hold got=%0d exp=%0d", dout, held); end
        end
        en = 1'b1;
        step();
        checks++;
        if (count !== 6'd31) begin failures++; $display("FAIL enable_resume got=%0d exp=31", count); end
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_count == 1) sample = DW'($urandom_range(200, 1));
            checks++;
            if (dout !== exp_out()) begin failures++; $display("FAIL enable_out cyc=%0d got=%0d exp=%0d", i, dout, exp_out()); end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [DW-1:0] vals [70];
        logic signed [DW-1:0] trace [70*64];
        int idx;
        rst = 1'b1;
        step();
        checks++;
        if (count !== 6'd0 || dout !== 16'sd0 || ph0 !== 1'b1) begin
            failures++; $display("FAIL midreset_clear count=%0d out=%0d ph0=%b exp=0/0/1", count, dout, ph0);
        end
        rst = 1'b0;
        for (int f = 0; f < 70; f++) vals[f] = DW'($urandom_range(400)) - 16'sd200;
        for (int rep = 0; rep < 2; rep++) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            idx = 0;
            sample = vals[0];
            for (int c = 0; c < 70 * 64; c++) begin
                step();
                if (m_count == 1) begin
                    sample = vals[idx % 70];
                    idx++;
                end
                checks++;
                if (dout !== exp_out()) begin failures++; $display("FAIL replay_model rep=%0d cyc=%0d got=%0d exp=%0d", rep, c, dout, exp_out()); end
                if (rep == 0) begin
                    trace[c] = dout;
                end else begin
                    checks++;
                    if (dout !== trace[c]) begin failures++; $display("FAIL replay_match cyc=%0d got=%0d exp=%0d", c, dout, trace[c]); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sample = '0; m_count = 0;
        test_reset();
        test_count();
        test_impulse();
        test_random();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
